fp_decode: RTL and testbench
============================

FP_DECODE -- requirements
Module: fp_decode

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  S/E/F present a word to decode.
REQ-005 in_ready  output  1  block can accept a word; high only in IDLE.
REQ-006 S  input  1  sign (1 = negative).
REQ-007 E  input  3  exponent, 0..7.
REQ-008 F  input  5  significand, 0..31, unsigned.
REQ-009 out_valid  output  1  D holds a completed result; high only in DONE.
REQ-010 out_ready  input  1  consumer takes D.
REQ-011 D  output  13  two's-complement linear value.
REQ-012 busy  output  1  high in SHIFT, SIGN and DONE.

Function
REQ-013 The block SHALL compute D = (S ? -1 : +1) * (F << E), as a 13-bit two's-complement result.
REQ-014 The magnitude SHALL stay within 0..3968 (31<<7), so D SHALL never overflow; no saturation logic.
REQ-015 The FSM SHALL have exactly four states: IDLE, SHIFT, SIGN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid at an edge (accept), the block SHALL latch S, cnt<=E and mag<={8'b0,F}.
REQ-017 Accept transition: go to SHIFT if E!=0, else go directly to SIGN.
REQ-018 SHIFT: each edge, mag<=mag<<1 and cnt<=cnt-1; leave for SIGN on the edge where cnt==1.
REQ-019 SHIFT SHALL perform exactly one shift per cycle and exactly E shifts in total.
REQ-020 SIGN: one edge; D<=S ? (~mag+1) : mag; go to DONE.
REQ-021 S=1 with mag=0 SHALL yield D=0 (no negative zero).
REQ-022 DONE: out_valid=1, D held stable; on out_ready, go to IDLE with out_valid=0 on the next cycle.
REQ-023 DONE with out_ready=0 SHALL hold D and out_valid indefinitely.
REQ-024 Latency: out_valid SHALL rise exactly E+2 edges after the accept edge (E=0 -> 2, E=7 -> 9).
REQ-025 in_valid outside IDLE SHALL be ignored; S/E/F changes after accept SHALL not affect the result in flight.
REQ-026 D SHALL retain the last result after DONE->IDLE, until the next SIGN state.
REQ-027 Back-to-back: accept is possible in the cycle right after DONE->IDLE; no in_ready-to-out_ready combinational path.
REQ-028 All outputs SHALL be registered or decoded from state only.

Reset
REQ-029 rst high at an edge SHALL force IDLE from any state, including mid-SHIFT.
REQ-030 Reset values: D=0, out_valid=0, busy=0, in_ready=1, cnt=0, mag=0.
REQ-031 rst SHALL take priority over in_valid and out_ready in the same cycle.
REQ-032 A word in flight at reset SHALL be discarded; no out_valid for it.

Verification
REQ-033 S=0,E=0,F=1, out_ready=1 -> D=13'h0001, out_valid 2 edges after accept, high one cycle.
REQ-034 S=0,E=7,F=31 -> D=3968 (13'h0F80), out_valid 9 edges after accept; busy high throughout.
REQ-035 S=1,E=3,F=5 -> D=-40 (13'h1FD8) after 5 edges; S=1,E=0,F=0 -> D=0.
REQ-036 Backpressure: out_ready=0 for 10 cycles in DONE -> D and out_valid stable; in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-037 rst pulse during SHIFT (E=6, 2 shifts done) -> next cycle IDLE, D=0, out_valid=0; the following word decodes correctly.
REQ-038 Exhaustive sweep over all 512 {S,E,F} -> D matches REQ-013 with per-word latency per REQ-024.

Source files
------------

// File: rtl/fp_decode_if.sv
// Word-in / result-out bus of the floating-point-to-linear decoder.
// A transfer happens on a rising edge where valid and ready are both high; the producer holds its payload until then, and ready never depends combinationally on valid.
interface fp_decode_if;
   logic        in_valid;
   logic        in_ready;
   logic        S;
   logic [2:0]  E;
   logic [4:0]  F;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] D;

   modport master (
      output in_valid, S, E, F, out_ready,
      input  in_ready, out_valid, D
   );

   modport slave (
      input  in_valid, S, E, F, out_ready,
      output in_ready, out_valid, D
   );
endinterface

// File: rtl/fp_decode.sv
// Sequential decoder: D = (S ? -1 : +1) * (F << E).
// The shift runs one bit per cycle, then a single cycle applies the sign.
module fp_decode (
   input  logic        clk,
   input  logic        rst,
   fp_decode_if.slave  bus,
   output logic        busy,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, SIGN = 2'd2, DONE = 2'd3} state_t;

   state_t      state;
   state_t      state_nx;
   logic        s_q;
   logic [2:0]  cnt;
   logic [12:0] mag;
   logic [12:0] d_q;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.in_valid) state_nx = (bus.E != 3'd0) ? SHIFT : SIGN;
         SHIFT:   if (cnt == 3'd1)  state_nx = SIGN;
         SIGN:    state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state == IDLE);
      bus.out_valid = (state == DONE);
      bus.D         = d_q;
      busy          = (state != IDLE);
      state_dbg     = state;
   end

   // Magnitude never exceeds 31<<7, so the 13-bit negate cannot overflow; -0 folds to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q <= 1'b0;
         cnt <= 3'd0;
         mag <= 13'd0;
         d_q <= 13'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  s_q <= bus.S;
                  cnt <= bus.E;
                  mag <= {8'b0, bus.F};
               end
            end
            SHIFT: begin
               mag <= mag << 1;
               cnt <= cnt - 3'd1;
            end
            SIGN:    d_q <= s_q ? (~mag + 13'd1) : mag;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_decode.sv
// Self-checking bench for fp_decode: directed corner words, reset mid-flight,
// backpressure, then a shuffled sweep of all 512 {S,E,F} words.
module tb_fp_decode;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [1:0] state_dbg;

   fp_decode_if bus ();

   fp_decode dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [12:0] exp_q[$];
   int          order[512];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
      end
   endtask

   // Reference: plain signed arithmetic, truncated to 13 bits.
   function automatic logic [12:0] model(input bit s, input int e, input int f);
      int v;
      v = f * (1 << e);
      if (s) v = -v;
      return v[12:0];
   endfunction

   task automatic send(input bit s, input int e, input int f, input int hold);
      int          n;
      logic [12:0] exp;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); @(negedge clk); n++;
      end
      chk("in_ready_before_accept", bus.in_ready, 1);
      bus.S = s; bus.E = e[2:0]; bus.F = f[4:0]; bus.in_valid = 1'b1;
      exp_q.push_back(model(s, e, f));
      @(posedge clk); n = 1; @(negedge clk);
      bus.in_valid = 1'b0;
      bus.S = 1'($urandom); bus.E = 3'($urandom); bus.F = 5'($urandom);
      while (!bus.out_valid && n < 20) begin
         chk("busy_in_flight", busy, 1);
         bus.in_valid = 1'($urandom_range(0, 1));
         @(posedge clk); n++; @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("latency", n, e + 2);
      exp = exp_q.pop_front();
      chk("d_value", bus.D, exp);
      chk("busy_done", busy, 1);
      for (int i = 0; i < hold; i++) begin
         bus.out_ready = 1'b0;
         bus.in_valid  = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
         chk("hold_out_valid", bus.out_valid, 1);
         chk("hold_d", bus.D, exp);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("out_valid_drop", bus.out_valid, 0);
      chk("in_ready_back", bus.in_ready, 1);
      chk("d_retained", bus.D, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.S = 1'b0; bus.E = 3'd0; bus.F = 5'd0; bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_d", bus.D, 0);
      chk("rst_state", state_dbg, 0);
      rst = 1'b0;

      send(0, 0, 1, 0);
      send(0, 7, 31, 0);
      send(1, 3, 5, 0);
      send(1, 0, 0, 0);
      send(1, 7, 31, 10);

      // Reset two shifts into an E=6 word: the word must vanish.
      bus.S = 1'b0; bus.E = 3'd6; bus.F = 5'd9; bus.in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk("midrst_in_ready", bus.in_ready, 1);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_d", bus.D, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_state", state_dbg, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); @(negedge clk);
         chk("midrst_no_output", bus.out_valid, 0);
      end
      send(0, 6, 9, 0);

      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         int j, t;
         j = $urandom_range(0, i);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         logic [8:0] w;
         int         hold;
         w = order[i][8:0];
         hold = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
         send(w[8], int'(w[7:5]), int'(w[4:0]), hold);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
